// File: rtl/btb_bht_predictor.sv
// Direct-mapped branch target buffer with optional 2-bit bimodal counters.
// Ports: clk/rst; IF lookup (if_pc -> pred_taken/pred_pc); EX resolve
// (ex_* in -> ex_mispredict/ex_correct_pc, table update); stat_* counters.
module btb_bht_predictor #(
    parameter int ENTRIES = 64,
    parameter int MODE    = 1,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_pc,
    input  logic              ex_br,
    input  logic [31:0]       ex_pc,
    input  logic              ex_taken,
    input  logic [31:0]       ex_target,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_pc,
    output logic              ex_mispredict,
    output logic [31:0]       ex_correct_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_cnt    [ENTRIES];

    logic [STAT_W-1:0] r_branches;
    logic [STAT_W-1:0] r_mispredicts;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;

    // IF lookup: reads registered state only, so a same-cycle update to
    // the same index is seen one cycle later.
    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[31:IDX_W+2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    assign pred_taken = (MODE == 1) ? (w_if_hit && r_cnt[w_if_idx][1])
                                    : w_if_hit;
    assign pred_pc    = pred_taken ? r_target[w_if_idx] : if_pc + 32'd4;

    // EX resolve: a taken branch also mispredicts when the fetched
    // target differs from the real one.
    assign ex_mispredict = ex_br &&
                           ((ex_taken != ex_pred_taken) ||
                            (ex_taken && (ex_pred_pc != ex_target)));
    assign ex_correct_pc = ex_taken ? ex_target : ex_pc + 32'd4;

    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[31:IDX_W+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= 2'b01;
            end
        end else if (ex_br) begin
            if (w_ex_hit) begin
                if (MODE == 1) begin
                    if (ex_taken) begin
                        r_target[w_ex_idx] <= ex_target;
                        if (r_cnt[w_ex_idx] != 2'b11)
                            r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + 2'd1;
                    end else if (r_cnt[w_ex_idx] != 2'b00) begin
                        r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - 2'd1;
                    end
                end else begin
                    // Without counters a not-taken hit simply evicts.
                    if (ex_taken)
                        r_target[w_ex_idx] <= ex_target;
                    else
                        r_valid[w_ex_idx] <= 1'b0;
                end
            end else if (ex_taken) begin
                // Allocate weakly taken so one not-taken flips it back.
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= ex_target;
                r_cnt[w_ex_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branches    <= '0;
            r_mispredicts <= '0;
        end else if (ex_br) begin
            r_branches <= r_branches + STAT_W'(1);
            if (ex_mispredict)
                r_mispredicts <= r_mispredicts + STAT_W'(1);
        end
    end

    assign stat_branches    = r_branches;
    assign stat_mispredicts = r_mispredicts;

endmodule
